mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit.sv | 159 +++++++++++++++
 tb/tb_mul_div_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers, one bit per cycle.
// Optional MTHI/MTLO write ports are enabled by defining MDU_MTHILO_EN.
module mul_div_unit #(
    parameter int unsigned DP_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [1:0]          op_i,
    input  logic [DP_WIDTH-1:0] a_i,
    input  logic [DP_WIDTH-1:0] b_i,
`ifdef MDU_MTHILO_EN
    input  logic                wr_hi_i,
    input  logic                wr_lo_i,
    input  logic [DP_WIDTH-1:0] wdata_i,
`endif
    output logic                busy_o,
    output logic                done_o,
    output logic                div_by_zero_o,
    output logic [DP_WIDTH-1:0] hi_o,
    output logic [DP_WIDTH-1:0] lo_o
);
    localparam int unsigned W    = DP_WIDTH;
    localparam int unsigned CntW = $clog2(DP_WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    divisor_q, divisor_d;
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            dbz_q, dbz_d;
    logic            dbz_out_q, dbz_out_d;
    logic            done_q, done_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;

    logic            is_signed;
    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      mul_sum, div_diff;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    quot, rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        divisor_d = divisor_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dbz_d     = dbz_q;
        dbz_out_d = dbz_out_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        is_signed = ~op_i[0];
        mag_a     = (is_signed && a_i[W-1]) ? -a_i : a_i;
        mag_b     = (is_signed && b_i[W-1]) ? -b_i : b_i;
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, divisor_q} : {(W+1){1'b0}});
        // Partial remainder (W bits) shifted left with the next dividend bit appended.
        div_diff  = acc_q[2*W-1:W-1] - {1'b0, divisor_q};
        prod      = neg_q ? -acc_q : acc_q;
        quot      = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem       = rem_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

        unique case (state_q)
            StIdle: begin
`ifdef MDU_MTHILO_EN
                if (wr_hi_i) hi_d = wdata_i;
                if (wr_lo_i) lo_d = wdata_i;
`endif
                if (start_i) begin
                    is_div_d  = op_i[1];
                    divisor_d = mag_b;
                    cnt_d     = '0;
                    neg_d     = is_signed && (a_i[W-1] ^ b_i[W-1]);
                    rem_neg_d = is_signed && op_i[1] && a_i[W-1];
                    if (op_i[1] && (b_i == '0)) begin
                        // Keep the raw dividend; it becomes HI on the FIX edge.
                        acc_d   = {{W{1'b0}}, a_i};
                        dbz_d   = 1'b1;
                        state_d = StFix;
                    end else begin
                        acc_d   = {{W{1'b0}}, mag_a};
                        dbz_d   = 1'b0;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (is_div_q) begin
                    if (!div_diff[W]) acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
                    else              acc_d = {acc_q[2*W-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[W-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(W - 1)) state_d = StFix;
            end
            StFix: begin
                done_d    = 1'b1;
                dbz_out_d = dbz_q;
                state_d   = StIdle;
                if (dbz_q) begin
                    hi_d = acc_q[W-1:0];
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quot;
                end else begin
                    hi_d = prod[2*W-1:W];
                    lo_d = prod[W-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            divisor_q <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            dbz_out_q <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            divisor_q <= divisor_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dbz_q     <= dbz_d;
            dbz_out_q <= dbz_out_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_out_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (DP_WIDTH=32), checks by immediate assertions.
// MTHI/MTLO steps run only when MDU_MTHILO_EN is defined.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;
`ifdef MDU_MTHILO_EN
    logic        wr_hi, wr_lo;
    logic [31:0] wdata;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mul_div_unit #(.DP_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .op_i          (op),
        .a_i           (a),
        .b_i           (b),
`ifdef MDU_MTHILO_EN
        .wr_hi_i       (wr_hi),
        .wr_lo_i       (wr_lo),
        .wdata_i       (wdata),
`endif
        .busy_o        (busy),
        .done_o        (done),
        .div_by_zero_o (dbz),
        .hi_o          (hi),
        .lo_o          (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op; lat = edges from the start edge to the done sample, busy_cyc = busy samples.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int busy_cyc);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
        lat = 0;
        busy_cyc = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cyc++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, bc, seen;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
`ifdef MDU_MTHILO_EN
        wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
`endif
        tick(); tick();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hilo", {hi, lo}, 64'h0);
        chk("reset_dbz", dbz, 0);

        // MULTU all-ones squared
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        chk("multu_lat", lat, 33);
        chk("multu_busy_cycles", bc, 33);
        chk("multu_busy_in_done", busy, 0);
        chk("multu_result", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        tick();
        chk("done_single_pulse", done, 0);
        chk("hold_after_done", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // MULT -3 * 5, then DIVU 7/2 issued in the done cycle
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, lat, bc);
        chk("mult_neg_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(2'b11, 32'd7, 32'd2, lat, bc);
        chk("b2b_divu_lat", lat, 33);
        chk("b2b_divu_result", {hi, lo}, {32'd1, 32'd3});

        // Signed divides
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bc);
        chk("div_neg_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
        chk("div_overflow_dbz", dbz, 0);
        run_op(2'b10, 32'd100, 32'hFFFF_FFF9, lat, bc);
        chk("div_pos_by_neg", {hi, lo}, 64'h0000_0002_FFFF_FFF2);

        // Divide by zero, then a normal op clears the flag
        run_op(2'b11, 32'd5, 32'd0, lat, bc);
        chk("dbz_lat", lat, 1);
        chk("dbz_flag", dbz, 1);
        chk("dbz_result", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0, lat, bc);
        chk("dbz_signed_result", {hi, lo}, 64'hFFFF_FFF0_FFFF_FFFF);
        run_op(2'b01, 32'd6, 32'd7, lat, bc);
        chk("dbz_cleared", dbz, 0);
        chk("multu_small", {hi, lo}, 64'd42);

        // MULTU 3x4 with a stray start while busy
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; op = 2'b11; a = 32'd99; b = 32'd0;
        tick();
        start = 1'b0;
        lat = 5;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        chk("ignored_start_lat", lat, 33);
        chk("ignored_start_result", {hi, lo}, 64'd12);
        chk("ignored_start_dbz", dbz, 0);

        // Reset mid-operation aborts with no done pulse
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hilo", {hi, lo}, 64'h0);
        seen = 0;
        repeat (40) begin
            tick();
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);

`ifdef MDU_MTHILO_EN
        wr_hi = 1'b1; wdata = 32'h1234;
        tick();
        wr_hi = 1'b0;
        chk("mthi_idle", hi, 32'h1234);
        wr_lo = 1'b1; wdata = 32'h55AA;
        tick();
        wr_lo = 1'b0;
        chk("mtlo_idle", lo, 32'h55AA);
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        tick();
        start = 1'b0;
        wr_hi = 1'b1; wdata = 32'h5678;
        tick();
        wr_hi = 1'b0;
        chk("mthi_busy_ignored", hi, 32'h1234);
        lat = 2;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        chk("mthilo_op_result", {hi, lo}, 64'd12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
